// File: rtl/muldiv_if.sv
// Handshake and data bundle between the EX stage and the iterative multiply/divide unit.
// The EX stage drives the master side. The unit drives the slave side.
interface muldiv_if;
    logic        start;
    logic [5:0]  funct;
    logic        flush;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] result;

    modport master (
        output start, funct, flush, operand_1, operand_2,
        input  busy, done, hi, lo, result
    );

    modport slave (
        input  start, funct, flush, operand_1, operand_2,
        output busy, done, hi, lo, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit that owns HI/LO and serves MTHI/MTLO/MFHI/MFLO.
// Every multiply or divide has a fixed 34-cycle latency: 32 radix-2 steps, one sign-fix cycle, then DONE.
module muldiv_unit (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_m;
    logic [31:0] r_raw1;
    logic [63:0] r_acc;
    logic        r_neg_a;
    logic        r_neg_b;
    logic        r_is_div;
    logic        r_div0;

    logic        w_is_md;
    logic        w_signed_op;
    logic        w_div_op;
    logic        w_idle_start;
    logic        w_launch;
    logic        w_mt_hi;
    logic        w_mt_lo;
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic [32:0] w_sum;
    logic [63:0] w_mul_acc;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic        w_ok;
    logic [63:0] w_div_acc;
    logic        w_neg_res;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;
    logic        w_busy;
    logic        w_done;
    logic [31:0] w_result;

    // Funct codes 0x18..0x1B: bit 1 selects divide, bit 0 selects unsigned.
    assign w_is_md      = (bus.funct[5:2] == 4'b0110);
    assign w_signed_op  = ~bus.funct[0];
    assign w_div_op     = bus.funct[1];
    assign w_idle_start = (r_state == S_IDLE) && bus.start && !bus.flush;
    assign w_launch     = w_idle_start && w_is_md;
    assign w_mt_hi      = w_idle_start && (bus.funct == 6'h11);
    assign w_mt_lo      = w_idle_start && (bus.funct == 6'h13);

    assign w_abs1 = (w_signed_op && bus.operand_1[31]) ? (32'd0 - bus.operand_1) : bus.operand_1;
    assign w_abs2 = (w_signed_op && bus.operand_2[31]) ? (32'd0 - bus.operand_2) : bus.operand_2;

    // Multiply: multiplier sits in the low half and is shifted out as the product shifts in.
    assign w_sum     = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_m} : 33'd0);
    assign w_mul_acc = {w_sum, r_acc[31:1]};

    // Restoring divide: remainder in the high half, dividend bits become quotient bits.
    assign w_rem_sh  = r_acc[63:31];
    assign w_diff    = w_rem_sh - {1'b0, r_m};
    assign w_ok      = ~w_diff[32];
    assign w_div_acc = {(w_ok ? w_diff[31:0] : w_rem_sh[31:0]), r_acc[30:0], w_ok};

    assign w_neg_res = r_neg_a ^ r_neg_b;
    assign w_prod    = w_neg_res ? (64'd0 - r_acc) : r_acc;
    assign w_quot    = w_neg_res ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem     = r_neg_a ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    always_comb begin
        w_fix_hi = w_prod[63:32];
        w_fix_lo = w_prod[31:0];
        if (r_is_div) begin
            if (r_div0) begin
                w_fix_hi = r_raw1;
                w_fix_lo = '1;
            end else begin
                w_fix_hi = w_rem;
                w_fix_lo = w_quot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_next = S_CALC;
                    w_busy = 1'b1;
                end
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (r_cnt == 5'd31) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_busy = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (bus.flush) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_m      <= '0;
            r_raw1   <= '0;
            r_acc    <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_is_div <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            if (w_mt_hi) begin
                r_hi <= bus.operand_1;
            end
            if (w_mt_lo) begin
                r_lo <= bus.operand_1;
            end
            if (bus.flush) begin
                r_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_launch) begin
                            r_cnt    <= '0;
                            r_neg_a  <= w_signed_op && bus.operand_1[31];
                            r_neg_b  <= w_signed_op && bus.operand_2[31];
                            r_is_div <= w_div_op;
                            r_div0   <= (bus.operand_2 == '0);
                            r_raw1   <= bus.operand_1;
                            r_m      <= w_div_op ? w_abs2 : w_abs1;
                            r_acc    <= {32'd0, (w_div_op ? w_abs1 : w_abs2)};
                        end
                    end
                    S_CALC: begin
                        r_acc <= r_is_div ? w_div_acc : w_mul_acc;
                        r_cnt <= r_cnt + 5'd1;
                    end
                    S_FIX: begin
                        r_hi <= w_fix_hi;
                        r_lo <= w_fix_lo;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_result = '0;
        case (bus.funct)
            6'h10:   w_result = r_hi;
            6'h12:   w_result = r_lo;
            default: w_result = '0;
        endcase
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.hi     = r_hi;
    assign bus.lo     = r_lo;
    assign bus.result = w_result;
endmodule
